// File: rtl/cvp_mem_pkg.sv
// Shared types and constants for the CVP memory controller and its storage array.
package cvp_mem_pkg;

  localparam int unsigned DATA_W = 16;
  localparam logic [15:0] HALT_ADDR        = 16'hFFFF;
  localparam logic [15:0] WP_LIMIT_DEFAULT = 16'h0100;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_BOOT,
    ST_RUN,
    ST_HALT
  } state_t;

endpackage

// File: rtl/cvp_sram.sv
// Single-port synchronous word memory; read data is registered and returns pre-write contents.
module cvp_sram #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              re,
  input  logic              we,
  input  logic              clr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage has no reset so contents survive a controller reset.
  always_ff @(posedge clk) begin
    if (rst_n && we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)   rdata <= '0;
    else if (clr) rdata <= '0;
    else if (re)  rdata <= mem[addr];
  end

endmodule

// File: rtl/cvp_mem_ctrl.sv
// Boot loader / memory front-end for the CVP processor.
// Optional write protection of the program region is enabled by defining MEM_WRITE_PROTECT_EN.
module cvp_mem_ctrl
  import cvp_mem_pkg::*;
#(
  parameter int unsigned ADDR_W   = 10,
  parameter logic [15:0] WP_LIMIT = WP_LIMIT_DEFAULT
) (
  input  logic        Clk1,
  input  logic        Reset,
  input  logic [15:0] Addr,
  input  logic        RD,
  input  logic        WR,
  input  logic [15:0] DataOut,
  input  logic        V,
  input  logic        ld_valid,
  input  logic [15:0] ld_data,
  input  logic        ld_last,
  output logic [15:0] DataIn,
  output logic        ld_ready,
  output logic        cpu_reset,
  output logic        halted,
  output logic        wp_err,
  output logic [7:0]  ovf_count
);

`ifdef MEM_WRITE_PROTECT_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif

  state_t              state, next_state;
  logic [ADDR_W-1:0]   ptr;
  logic                v_q;
  logic                in_range, halt_req, wp_hit;
  logic                mem_re, mem_we, mem_clr;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;

  assign in_range = ((32'(Addr) >> ADDR_W) == 32'd0);
  assign halt_req = WR && (Addr == HALT_ADDR);
  assign wp_hit   = WP_EN && WR && in_range && (Addr < WP_LIMIT);

  always_ff @(posedge Clk1) begin
    if (!Reset) state <= ST_LOAD;
    else        state <= next_state;
  end

  // Next state and memory port mux: loader owns the port in LOAD, processor in RUN.
  always_comb begin
    next_state = state;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_clr    = 1'b0;
    mem_addr   = ptr;
    mem_wdata  = ld_data;
    case (state)
      ST_LOAD: begin
        mem_we = ld_valid;
        if (ld_valid && ld_last) next_state = ST_BOOT;
      end
      ST_BOOT: next_state = ST_RUN;
      ST_RUN: begin
        mem_addr  = Addr[ADDR_W-1:0];
        mem_wdata = DataOut;
        mem_re    = RD && in_range;
        mem_clr   = RD && !in_range;
        mem_we    = WR && in_range && !halt_req && !wp_hit;
        if (halt_req) next_state = ST_HALT;
      end
      ST_HALT: next_state = ST_HALT;
      default: next_state = ST_LOAD;
    endcase
  end

  // Status outputs are registered from next_state so they track the state register.
  always_ff @(posedge Clk1) begin
    if (!Reset) begin
      ptr       <= '0;
      v_q       <= 1'b0;
      ovf_count <= '0;
      halted    <= 1'b0;
      wp_err    <= 1'b0;
      ld_ready  <= 1'b1;
      cpu_reset <= 1'b1;
    end else begin
      if (state == ST_LOAD && ld_valid) ptr <= ptr + ADDR_W'(1);
      v_q <= V;
      if (state == ST_RUN && V && !v_q && ovf_count != 8'hFF)
        ovf_count <= ovf_count + 8'd1;
      if (state == ST_RUN && wp_hit) wp_err <= 1'b1;
      halted    <= (next_state == ST_HALT);
      ld_ready  <= (next_state == ST_LOAD);
      cpu_reset <= (next_state != ST_RUN);
    end
  end

  cvp_sram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_sram (
    .clk   (Clk1),
    .rst_n (Reset),
    .re    (mem_re),
    .we    (mem_we),
    .clr   (mem_clr),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (DataIn)
  );

endmodule

// File: tb/tb_cvp_mem_ctrl.sv
// Directed scoreboard bench for cvp_mem_ctrl: load, boot, read/write, overflow count, halt and reset.
module tb_cvp_mem_ctrl;

  logic        Clk1 = 1'b0;
  logic        Reset, RD, WR, V, ld_valid, ld_last;
  logic [15:0] Addr, DataOut, ld_data;
  logic [15:0] DataIn;
  logic        ld_ready, cpu_reset, halted, wp_err;
  logic [7:0]  ovf_count;

  logic [15:0] exp_q [$];
  int errors = 0;
  int checks = 0;

  cvp_mem_ctrl dut (
    .Clk1      (Clk1),
    .Reset     (Reset),
    .Addr      (Addr),
    .RD        (RD),
    .WR        (WR),
    .DataOut   (DataOut),
    .V         (V),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .DataIn    (DataIn),
    .ld_ready  (ld_ready),
    .cpu_reset (cpu_reset),
    .halted    (halted),
    .wp_err    (wp_err),
    .ovf_count (ovf_count)
  );

  always #5 Clk1 = ~Clk1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk1);
    #1;
  endtask

  task automatic chk_rd(input string tag);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed=%h expected=<scoreboard empty>", tag, DataIn);
    end else begin
      e = exp_q.pop_front();
      chk(tag, DataIn, e);
    end
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] e);
    Addr = a;
    RD   = 1'b1;
    exp_q.push_back(e);
    tick();
    RD = 1'b0;
    chk_rd(tag);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    Addr    = a;
    DataOut = d;
    WR      = 1'b1;
    tick();
    WR = 1'b0;
  endtask

  task automatic ld_word(input logic [15:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    tick();
    tick();
    Reset = 1'b1;
  endtask

  task automatic pulse_v(input int n);
    for (int i = 0; i < n; i++) begin
      V = 1'b1;
      tick();
      V = 1'b0;
      tick();
    end
  endtask

  initial begin
    Reset = 1'b0; RD = 1'b0; WR = 1'b0; V = 1'b0;
    ld_valid = 1'b0; ld_last = 1'b0;
    Addr = '0; DataOut = '0; ld_data = '0;
    tick();
    tick();
    chk("rst_datain",    DataIn, 16'h0000);
    chk("rst_ld_ready",  16'(ld_ready), 16'h1);
    chk("rst_cpu_reset", 16'(cpu_reset), 16'h1);
    chk("rst_halted",    16'(halted), 16'h0);
    chk("rst_wp_err",    16'(wp_err), 16'h0);
    chk("rst_ovf",       16'(ovf_count), 16'h0);
    Reset = 1'b1;

    // Abort a load after two words; the next load must restart at address 0.
    ld_word(16'hAAAA, 1'b0);
    ld_word(16'hBBBB, 1'b0);
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    chk("midload_ld_ready",  16'(ld_ready), 16'h1);
    chk("midload_cpu_reset", 16'(cpu_reset), 16'h1);

    ld_word(16'h1111, 1'b0);
    ld_word(16'h2222, 1'b0);
    ld_word(16'h3333, 1'b1);
    chk("boot_cpu_reset", 16'(cpu_reset), 16'h1);
    chk("boot_ld_ready",  16'(ld_ready), 16'h0);
    tick();
    chk("run_cpu_reset",  16'(cpu_reset), 16'h0);

    rd("rd_addr0", 16'h0000, 16'h1111);
    rd("rd_addr1", 16'h0001, 16'h2222);
    rd("rd_addr2", 16'h0002, 16'h3333);
    rd("rd_oor",   16'h0400, 16'h0000);
    rd("rd_addr1b", 16'h0001, 16'h2222);
    exp_q.push_back(16'h2222);
    tick();
    chk_rd("datain_hold");

    // Same-address read and write returns the old word.
    Addr = 16'h0002; DataOut = 16'hABCD; RD = 1'b1; WR = 1'b1;
    exp_q.push_back(16'h3333);
    tick();
    RD = 1'b0; WR = 1'b0;
    chk_rd("rbw_old");
    rd("rbw_new", 16'h0002, 16'hABCD);

    wr(16'h0100, 16'h1234);
    wr(16'h0500, 16'h9999);
    rd("oor_wr_dropped", 16'h0100, 16'h1234);

    wr(16'h0003, 16'h5555);
    ld_valid = 1'b1; ld_data = 16'hDEAD; ld_last = 1'b1;
    tick();
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("run_ld_ready", 16'(ld_ready), 16'h0);
    rd("ld_ignored", 16'h0003, 16'h5555);

    wr(16'h0010, 16'h4242);
    wr(16'h0001, 16'h4242);
`ifdef MEM_WRITE_PROTECT_EN
    chk("wp_err_set", 16'(wp_err), 16'h1);
    rd("wp_dropped", 16'h0001, 16'h2222);
`else
    chk("wp_err_zero", 16'(wp_err), 16'h0);
    rd("wp_lands_0010", 16'h0010, 16'h4242);
    rd("wp_lands_0001", 16'h0001, 16'h4242);
`endif

    pulse_v(5);
    chk("ovf_5", 16'(ovf_count), 16'd5);
    V = 1'b1;
    tick(); tick(); tick();
    V = 1'b0;
    tick();
    chk("ovf_level", 16'(ovf_count), 16'd6);
    pulse_v(294);
    chk("ovf_sat", 16'(ovf_count), 16'h00FF);

    wr(16'hFFFF, 16'h0000);
    chk("halt_halted",    16'(halted), 16'h1);
    chk("halt_cpu_reset", 16'(cpu_reset), 16'h1);
    Addr = 16'h0000; RD = 1'b1; ld_valid = 1'b1; ld_data = 16'h7777;
`ifdef MEM_WRITE_PROTECT_EN
    exp_q.push_back(16'h2222);
`else
    exp_q.push_back(16'h4242);
`endif
    tick();
    tick();
    RD = 1'b0; ld_valid = 1'b0;
    chk_rd("halt_no_read");
    chk("halt_stays", 16'(halted), 16'h1);

    do_reset();
    chk("rst2_halted",   16'(halted), 16'h0);
    chk("rst2_ovf",      16'(ovf_count), 16'h0);
    chk("rst2_wp_err",   16'(wp_err), 16'h0);
    chk("rst2_datain",   DataIn, 16'h0000);
    chk("rst2_ld_ready", 16'(ld_ready), 16'h1);

    ld_word(16'h0F0F, 1'b1);
    tick();
    rd("reload_addr0",  16'h0000, 16'h0F0F);
    rd("retained_addr2", 16'h0002, 16'hABCD);

    // Load one word past the top of memory; the pointer wraps onto address 0.
    do_reset();
    for (int i = 0; i <= 1024; i++) ld_word(16'(i) ^ 16'hC300, (i == 1024));
    tick();
    rd("wrap_addr0",    16'h0000, 16'hC700);
    rd("wrap_addr1",    16'h0001, 16'hC301);
    rd("wrap_addr3ff",  16'h03FF, 16'hC0FF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cvp_mem_ctrl.md
CVP_MEM_CTRL -- requirements
Module: cvp_mem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 10, log2 of the internal word memory depth (1024 x 16 bits).
REQ-002 Parameter WP_LIMIT, default 16'h0100, first address above the write-protected program region.
REQ-003 Clk1  input  1  sole clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-low reset.
REQ-005 Addr  input  16  word address from the processor.
REQ-006 RD  input  1  processor read strobe.
REQ-007 WR  input  1  processor write strobe.
REQ-008 DataOut  input  16  processor write data.
REQ-009 V  input  1  processor overflow flag.
REQ-010 ld_valid  input  1  loader word valid.
REQ-011 ld_data  input  16  loader word.
REQ-012 ld_last  input  1  marks the final loader word.
REQ-013 DataIn  output  16  read data to the processor.
REQ-014 ld_ready  output  1  loader may transfer.
REQ-015 cpu_reset  output  1  active-high reset driven to the processor's Reset.
REQ-016 halted  output  1  program signalled halt.
REQ-017 wp_err  output  1  sticky write-protect violation.
REQ-018 ovf_count  output  8  count of V rising edges.

Function
REQ-019 The FSM SHALL have states LOAD, BOOT, RUN and HALT.
REQ-020 In LOAD: ld_ready=1 and cpu_reset=1; each cycle with ld_valid=1 writes ld_data to mem[ptr] and increments ptr.
REQ-021 ptr SHALL wrap from 2^ADDR_W-1 to 0 without error.
REQ-022 An accepted word with ld_last=1 SHALL be written, then the FSM SHALL move LOAD->BOOT.
REQ-023 BOOT SHALL last exactly one cycle with cpu_reset=1, then the FSM SHALL enter RUN.
REQ-024 In RUN: ld_ready=0 and cpu_reset=0.
REQ-025 RD=1 with Addr < 2^ADDR_W SHALL register mem[Addr] onto DataIn one cycle later; otherwise DataIn holds its value.
REQ-026 RD=1 with an out-of-range Addr SHALL load 16'h0000 onto DataIn.
REQ-027 WR=1 with Addr in range SHALL write DataOut to mem[Addr].
REQ-028 WR=1 with an out-of-range Addr other than 16'hFFFF SHALL be dropped.
REQ-029 With RD and WR both set to the same address, the write SHALL occur and DataIn SHALL return the old data (read-before-write).
REQ-030 WR=1 with Addr=16'hFFFF in RUN SHALL move the FSM to HALT next cycle.
REQ-031 In HALT: halted=1, cpu_reset=1, no memory access; the FSM SHALL remain in HALT until Reset.
REQ-032 A 0->1 transition of V in RUN SHALL increment ovf_count, saturating at 8'hFF.
REQ-033 ld_valid outside LOAD SHALL be ignored.

Reset
REQ-034 Reset=0 at a clock edge SHALL enter LOAD from any state, including mid-load or mid-run.
REQ-035 On reset: ptr=0, DataIn=0, halted=0, wp_err=0, ovf_count=0, ld_ready=1, cpu_reset=1, V history=0.
REQ-036 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-037 With MEM_WRITE_PROTECT_EN defined, a RUN-state WR to Addr < WP_LIMIT SHALL be dropped and SHALL set wp_err until reset.
REQ-038 Without MEM_WRITE_PROTECT_EN, such writes SHALL proceed normally and wp_err SHALL be tied to 0.
REQ-039 Loader writes are never write-protected, with or without the macro.

Structure
REQ-040 A shared package cvp_mem_pkg SHALL hold the FSM state enum, HALT_ADDR=16'hFFFF and the default WP_LIMIT.
REQ-041 The storage array SHALL be a sub-module, cvp_sram, with one synchronous read/write port; the loader and processor ports are muxed in by state.

Verification
REQ-042 Load 3 words (1111, 2222, 3333, last on the third) -> mem[0..2] hold those values; cpu_reset=1 for one cycle after last, then 0.
REQ-043 In RUN, RD at Addr=1 -> DataIn=16'h2222 one cycle later; RD at Addr=16'h0400 -> DataIn=0.
REQ-044 RD and WR at Addr=2 with DataOut=16'hABCD -> DataIn=16'h3333; a later read of Addr=2 returns 16'hABCD.
REQ-045 With the macro defined, WR at Addr=16'h0010 -> memory unchanged and wp_err=1; without the macro -> write lands and wp_err=0.
REQ-046 Pulse V 300 times -> ovf_count=8'hFF; then WR at Addr=16'hFFFF -> halted=1 and cpu_reset=1 next cycle.
REQ-047 Reset=0 mid-load after 2 words -> state LOAD, ptr=0; the next load overwrites from address 0.
